// File: rtl/bram_reader_pkg.sv
//------------------------------------------------------------------------------
// Module   : bram_reader_pkg
// Brief    : Shared encodings and defaults for the BRAM capture writer/reader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bram_reader_pkg;

    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_DATA_W  = 32;
    localparam int BRAM_RD_LAT = 1;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bram_reader_stream_fifo2.sv
//------------------------------------------------------------------------------
// Module   : stream_fifo2
// Brief    : 2-entry {last, data} FIFO; head is held stable until popped.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    logic do_pop;
    logic do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign data_o  = data_q[rd_ptr_q];
    assign last_o  = last_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bram_reader.sv
//------------------------------------------------------------------------------
// Module   : bram_reader
// Brief    : Streams words 0..len-1 from BRAM port B as AXI4-Stream on rdy edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bram_reader
    import bram_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic              rdy_q;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              zero_done_q;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    logic              start;
    logic              tvalid;
    logic              pop;
    logic [2:0]        occ;
    logic              issue;
    logic              issue_last;
    logic              last_pop;

    assign start      = rdy & ~rdy_q;
    assign tvalid     = (fifo_count != 2'd0);
    assign pop        = tvalid & m_axis_tready;
    assign last_pop   = pop & head_last;
    // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == ST_RUN) && (rd_ptr_q < {1'b0, len_q}) && (occ < 3'd2);
    assign issue_last = (rd_ptr_q == ({1'b0, len_q} - PTR_ONE));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = ST_RUN;
                    len_d    = len;
                    rd_ptr_d = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rdy_q           <= 1'b0;
            len_q           <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            rdy_q           <= rdy;
            len_q           <= len_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & issue_last;
            zero_done_q     <= (state_q == ST_IDLE) & start & (len == '0);
        end
    end

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bram_dout),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .data_o      (head_data),
        .last_o      (head_last),
        .count_o     (fifo_count)
    );

    assign bram_en       = issue;
    assign bram_addr     = rd_ptr_q[ADDR_W-1:0];
    assign bram_we       = 4'b0000;
    assign m_axis_tdata  = head_data;
    assign m_axis_tvalid = tvalid;
    assign m_axis_tlast  = head_last & tvalid;
    assign busy          = (state_q == ST_RUN);
    assign done          = last_pop | zero_done_q;
    assign overrun       = start & (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_bram_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_bram_reader
// Brief    : Scoreboard bench for bram_reader with a 1-cycle-latency BRAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bram_reader;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef logic [DATA_W:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [DATA_W-1:0] bram_dout = '0;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              busy;
    logic              done;
    logic              overrun;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;

    beat_t             exp_q[$];
    beat_t             got_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    int    en_cnt = 0, acc_cnt = 0, tlast_cnt = 0, done_cnt = 0, ovr_cnt = 0;
    int    stab_err = 0, max_out = 0;
    logic  hold_q = 1'b0;
    beat_t hold_v;

    bram_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .len           (len),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_dout     (bram_dout),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    // Passive observer: records accepted beats, issued addresses and event counts.
    always @(negedge clk) begin
        if (rst) begin
            acc_cnt = en_cnt;
            hold_q  = 1'b0;
        end else begin
            if (hold_q && (!tvalid || ({tlast, tdata} !== hold_v))) stab_err++;
            hold_q = tvalid & ~tready;
            hold_v = {tlast, tdata};
            if (bram_en) begin
                en_cnt++;
                addr_q.push_back(bram_addr);
            end
            if (tvalid && tready) begin
                acc_cnt++;
                got_q.push_back({tlast, tdata});
                if (tlast) tlast_cnt++;
            end
            if (done) done_cnt++;
            if (overrun) ovr_cnt++;
            if (en_cnt - acc_cnt > max_out) max_out = en_cnt - acc_cnt;
        end
    end

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; tready = 1'b0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, overrun, tvalid, tlast, bram_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, overrun, tvalid, tlast, bram_en});
        end
        checks++;
        if (tdata !== '0 || bram_addr !== '0 || bram_we !== 4'b0) begin
            failures++;
            $display("FAIL reset_data tdata=%h addr=%h we=%h exp=0", tdata, bram_addr, bram_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] en_m, v_m, l_m, d_m, b_m;
        int gb, ab, k, bad;
        beat_t e;
        en_m = '0; v_m = '0; l_m = '0; d_m = '0; b_m = '0;
        gb = got_q.size(); ab = addr_q.size();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, mem[i]});
        rdy = 1'b1; len = 14'd4; tready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            en_m[c] = bram_en; v_m[c] = tvalid; l_m[c] = tlast; d_m[c] = done; b_m[c] = busy;
            @(posedge clk); #1;
            if (c == 1) rdy = 1'b0;
        end
        checks++; if (en_m !== 9'h01E) begin failures++; $display("FAIL basic_en got=%b exp=%b", en_m, 9'h01E); end
        checks++; if (v_m  !== 9'h078) begin failures++; $display("FAIL basic_tvalid got=%b exp=%b", v_m, 9'h078); end
        checks++; if (l_m  !== 9'h040) begin failures++; $display("FAIL basic_tlast got=%b exp=%b", l_m, 9'h040); end
        checks++; if (d_m  !== 9'h040) begin failures++; $display("FAIL basic_done got=%b exp=%b", d_m, 9'h040); end
        checks++; if (b_m  !== 9'h07E) begin failures++; $display("FAIL basic_busy got=%b exp=%b", b_m, 9'h07E); end
        bad = (addr_q.size() != ab + 4);
        for (int i = 0; i < 4 && !bad; i++) if (addr_q[ab+i] !== ADDR_W'(i)) bad = 1;
        checks++; if (bad) begin failures++; $display("FAIL basic_addr got_n=%0d exp_n=4 (addr 0..3)", addr_q.size() - ab); end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h exp=%h", k - gb, (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
    endtask

    task automatic test_backpressure();
        int gb, ab, eb, tb, sb, k, bad, fin;
        beat_t e;
        gb = got_q.size(); ab = addr_q.size(); eb = en_cnt; tb = tlast_cnt; sb = stab_err;
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, mem[i]});
        rdy = 1'b1; len = 14'd8; fin = 0;
        for (int c = 0; c < 100 && fin == 0; c++) begin
            tready = ((c % 2) == 0);
            @(negedge clk);
            if (done) fin = 1;
            @(posedge clk); #1;
            if (c == 1) rdy = 1'b0;
        end
        rdy = 1'b0; tready = 1'b1;
        checks++; if (fin == 0) begin failures++; $display("FAIL bp_timeout done=0 exp=1"); end
        checks++; if (en_cnt - eb != 8) begin failures++; $display("FAIL bp_reads got=%0d exp=8", en_cnt - eb); end
        checks++; if (tlast_cnt - tb != 1) begin failures++; $display("FAIL bp_tlast_n got=%0d exp=1", tlast_cnt - tb); end
        checks++; if (stab_err != sb) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err - sb); end
        checks++; if (max_out > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
        bad = (addr_q.size() != ab + 8);
        for (int i = 0; i < 8 && !bad; i++) if (addr_q[ab+i] !== ADDR_W'(i)) bad = 1;
        checks++; if (bad) begin failures++; $display("FAIL bp_addr got_n=%0d exp_n=8", addr_q.size() - ab); end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", k - gb, (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
    endtask

    task automatic test_len0();
        logic [4:0] en_m, v_m, d_m, b_m;
        en_m = '0; v_m = '0; d_m = '0; b_m = '0;
        rdy = 1'b1; len = '0; tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            en_m[c] = bram_en; v_m[c] = tvalid; d_m[c] = done; b_m[c] = busy;
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        checks++; if (d_m !== 5'b00010) begin failures++; $display("FAIL len0_done got=%b exp=00010", d_m); end
        checks++; if ({en_m, v_m, b_m} !== 15'b0) begin failures++; $display("FAIL len0_quiet en=%b tvalid=%b busy=%b exp=0", en_m, v_m, b_m); end
        @(posedge clk); #1;
    endtask

    task automatic test_overrun();
        int gb, eb, tb, ob, k, fin, ocyc;
        beat_t e;
        gb = got_q.size(); eb = en_cnt; tb = tlast_cnt; ob = ovr_cnt; ocyc = -1;
        for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, mem[i]});
        rdy = 1'b1; len = 14'd16; tready = 1'b1; fin = 0;
        for (int c = 0; c < 100 && fin == 0; c++) begin
            @(negedge clk);
            if (overrun) ocyc = c;
            if (done) fin = 1;
            @(posedge clk); #1;
            if (c == 1) rdy = 1'b0;
            if (c == 7) rdy = 1'b1;
        end
        rdy = 1'b0;
        checks++; if (fin == 0) begin failures++; $display("FAIL ovr_timeout done=0 exp=1"); end
        checks++; if (ovr_cnt - ob != 1 || ocyc != 8) begin failures++; $display("FAIL ovr_pulse n=%0d cycle=%0d exp n=1 cycle=8", ovr_cnt - ob, ocyc); end
        checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL ovr_reads got=%0d exp=16", en_cnt - eb); end
        checks++; if (tlast_cnt - tb != 1) begin failures++; $display("FAIL ovr_tlast_n got=%0d exp=1", tlast_cnt - tb); end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL ovr_beat%0d got=%h exp=%h", k - gb, (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int gb, ab, eb, tb, db, k, fin;
        beat_t e;
        gb = got_q.size(); tb = tlast_cnt; db = done_cnt;
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, mem[i]});
        rdy = 1'b1; len = 14'd16; tready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (c == 1) rdy = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, overrun, tvalid, tlast, bram_en} !== 6'b0 || tdata !== '0 || bram_addr !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs ctrl=%b tdata=%h addr=%h exp=0", {busy, done, overrun, tvalid, tlast, bram_en}, tdata, bram_addr);
        end
        checks++; if (got_q.size() - gb != 6) begin failures++; $display("FAIL rstmid_count got=%0d exp=6", got_q.size() - gb); end
        checks++; if (done_cnt != db || tlast_cnt != tb) begin failures++; $display("FAIL rstmid_abort done=%0d tlast=%0d exp=0", done_cnt - db, tlast_cnt - tb); end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL rstmid_beat%0d got=%h exp=%h", k - gb, (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
        @(posedge clk); #1;
        gb = got_q.size(); ab = addr_q.size(); eb = en_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back({i == 2, mem[i]});
        rdy = 1'b1; len = 14'd3; fin = 0;
        for (int c = 0; c < 50 && fin == 0; c++) begin
            @(negedge clk);
            if (done) fin = 1;
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        checks++; if (fin == 0) begin failures++; $display("FAIL restart_timeout done=0 exp=1"); end
        checks++;
        if (en_cnt - eb != 3 || addr_q.size() <= ab || addr_q[ab] !== '0) begin
            failures++;
            $display("FAIL restart_addr reads=%0d exp reads=3 from addr 0", en_cnt - eb);
        end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL restart_beat%0d got=%h exp=%h", k - gb, (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len1_stall();
        logic [15:0] en_m, v_m, l_m, d_m;
        int gb, k;
        beat_t e;
        en_m = '0; v_m = '0; l_m = '0; d_m = '0;
        gb = got_q.size();
        exp_q.push_back({1'b1, mem[0]});
        rdy = 1'b1; len = 14'd1;
        for (int c = 0; c < 16; c++) begin
            tready = (c >= 13);
            @(negedge clk);
            en_m[c] = bram_en; v_m[c] = tvalid; l_m[c] = tlast; d_m[c] = done;
            @(posedge clk); #1;
            if (c == 1) rdy = 1'b0;
        end
        checks++; if (en_m !== 16'h0002) begin failures++; $display("FAIL len1_en got=%b exp=%b", en_m, 16'h0002); end
        checks++; if (v_m  !== 16'h3FF8) begin failures++; $display("FAIL len1_tvalid got=%b exp=%b", v_m, 16'h3FF8); end
        checks++; if (l_m  !== 16'h3FF8) begin failures++; $display("FAIL len1_tlast got=%b exp=%b", l_m, 16'h3FF8); end
        checks++; if (d_m  !== 16'h2000) begin failures++; $display("FAIL len1_done got=%b exp=%b", d_m, 16'h2000); end
        k = gb;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (k >= got_q.size() || got_q[k] !== e) begin
                failures++;
                $display("FAIL len1_beat got=%h exp=%h", (k < got_q.size()) ? got_q[k] : '0, e);
            end
            k++;
        end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL hold_stable got=%0d exp=0", stab_err); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = {16'(i) ^ 16'hA5C3, 16'(i) + 16'h1357};
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_overrun();
        test_reset_mid();
        test_len1_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_reader.md
Name: bram_reader

Overview:
- Read-side counterpart of the receiver BRAM capture controller.
- Detects the writer's rdy (capture-complete) rising edge, reads words 0..len-1 from BRAM port B, and streams them out as AXI4-Stream to the DMA/PS path.
- Handles BRAM 1-cycle read latency and downstream backpressure via a 2-entry prefetch buffer; full throughput when tready stays high.

Parameters:
- ADDR_W, 14, BRAM word address width; also the width of len.
- DATA_W, 32, BRAM/stream data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  capture-complete level from writer; rising edge starts a readout.
- len  in  ADDR_W  number of words to read; latched at start.
- bram_addr  out  ADDR_W  port B word address.
- bram_en  out  1  port B enable; one read issued per high cycle.
- bram_we  out  4  port B byte write enables; constant 0.
- bram_dout  in  DATA_W  port B read data, valid 1 cycle after bram_en.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks word len-1.
- busy  out  1  readout in progress.
- done  out  1  1-cycle pulse when the last word is accepted, or on a len=0 start.
- overrun  out  1  1-cycle pulse when a rdy edge arrives while busy.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, rdy edge register cleared. Reset mid-readout aborts the stream immediately with no tlast and no done.
- Edge detection: rdy_q <= rdy each cycle. start = rdy & ~rdy_q.
- IDLE:
  - start with len != 0: latch len, rd_ptr=0, out_cnt=0, go to RUN. busy=1 from the next cycle.
  - start with len == 0: done pulse next cycle, stay IDLE.
- RUN, issue rule:
  - pop = tvalid & tready.
  - inflight = bram_en registered from the previous cycle.
  - Issue when rd_ptr < len and (count + inflight - pop) < 2.
  - On issue: bram_en=1, bram_addr=rd_ptr, rd_ptr++.
- RUN, capture: the cycle after an issue, bram_dout is written into the 2-entry FIFO together with a last flag (issued address == len-1).
- Output:
  - tvalid = (count != 0); tdata/tlast come from the FIFO head.
  - tdata/tlast stay stable while tvalid & ~tready.
  - Push and pop in the same cycle keep count unchanged.
- Completion: pop of the tlast entry gives done=1 that cycle, busy=0 and state IDLE next cycle.
- Latency: start sampled at cycle 0, first bram_en at cycle 1, first tvalid at cycle 3. With tready held high, one word per cycle and last accepted at cycle len+2.
- Overrun: start while busy pulses overrun for 1 cycle and is otherwise ignored; the current readout continues unchanged.
- Width rules: rd_ptr and out_cnt are ADDR_W+1 bits, so len=2^ADDR_W-1 does not wrap. bram_addr is rd_ptr[ADDR_W-1:0].
- bram_en is never asserted in IDLE. No more than len reads are ever issued.

Decomposition:
- Shared package (with the writer controller): state encodings ST_IDLE/ST_RUN, BRAM_RD_LAT=1, default ADDR_W/DATA_W.
- One sub-module: stream_fifo2, a 2-entry FIFO of {last, data} with push/pop/count, holding output stable under backpressure.

Test Plan:
- len=4, tready=1, rdy 0->1 at cycle 0 -> bram_en at cycles 1-4 with addr 0..3; tvalid at cycles 3-6 carrying mem[0..3]; tlast and done at cycle 6; busy low at cycle 7.
- len=8, tready toggling 1/0 each cycle -> all 8 words delivered in order; tdata stable on every tvalid&~tready cycle; never more than 2 reads outstanding; tlast only on word 7.
- len=0, rdy edge -> done pulse, no bram_en, no tvalid, busy stays 0.
- len=16, second rdy edge at word 5 -> overrun pulses 1 cycle; the stream finishes all 16 words with a single tlast.
- rst asserted for 1 cycle mid-stream (len=16, after 6 words) -> next cycle all outputs 0; a fresh rdy edge restarts from addr 0.
- len=1, tready=0 for 10 cycles then 1 -> exactly 1 read issued; tvalid with tlast held high for 10 cycles; done on the accept cycle.
